// File: rtl/div_seq.sv
// div_seq: sequential signed 16/8 restoring divider with an operand-pair FIFO
module div_seq #(
    parameter int FIFO_DEPTH = 16,
    parameter int DVD_W = 16,
    parameter int DVS_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_vld,
    input  logic [DVD_W-1:0] in0_data,
    input  logic [DVS_W-1:0] in1_data,
    output logic             in_rdy,
    output logic             div_busy,
    output logic             out_vld,
    output logic [DVD_W-1:0] out_quot,
    output logic [DVS_W-1:0] out_rem,
    output logic             out_dbz
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DVD_W);

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

    state_t           state, state_nx;
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [DVD_W-1:0] mem_dvd [FIFO_DEPTH];
    logic [DVS_W-1:0] mem_dvs [FIFO_DEPTH];
    logic             empty, full, acc, fin, load, pop, push;
    logic [DVD_W-1:0] src_dvd, qd, qd_nx, quot_fin;
    logic [DVS_W-1:0] src_dvs, dvs_q, r, r_nx, rem_fin, dvd_lo;
    logic [DVS_W:0]   r_sh;
    logic             ge, sign_q, sign_r, dvs_zero;
    logic [CW-1:0]    cnt;

    assign empty    = wr_ptr == rd_ptr;
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_rdy   = rst_n & ~full;
    assign acc      = div_vld & in_rdy;
    assign div_busy = (state != IDLE) | ~empty | div_vld | out_vld;
    assign src_dvd  = empty ? in0_data : mem_dvd[rd_ptr[AW-1:0]];
    assign src_dvs  = empty ? in1_data : mem_dvs[rd_ptr[AW-1:0]];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: a finishing engine may immediately reload when a pair is pending
    always_comb begin
        state_nx = load ? CALC : fin ? IDLE : (state == CALC && cnt == '0) ? SIGN : state;
    end

    // Control and result shaping; divide-by-zero finishes on its first CALC edge
    always_comb begin
        fin      = (state == SIGN) || (state == CALC && dvs_zero);
        load     = (state == IDLE || fin) && (acc || !empty);
        pop      = load && !empty;
        push     = acc && !(load && empty);
        r_sh     = {r, qd[DVD_W-1]};
        ge       = r_sh >= {1'b0, dvs_q};
        r_nx     = ge ? DVS_W'(r_sh - {1'b0, dvs_q}) : r_sh[DVS_W-1:0];
        qd_nx    = {qd[DVD_W-2:0], ge};
        quot_fin = dvs_zero ? '1 : sign_q ? -qd : qd;
        rem_fin  = dvs_zero ? dvd_lo : sign_r ? -r : r;
    end

    // Engine datapath and registered outputs; qd shifts dividend out while quotient shifts in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_quot <= '0;
            out_rem  <= '0;
            out_dbz  <= 1'b0;
            qd       <= '0;
            dvs_q    <= '0;
            r        <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            dvs_zero <= 1'b0;
            dvd_lo   <= '0;
        end else begin
            out_vld <= fin;
            if (fin) begin
                out_quot <= quot_fin;
                out_rem  <= rem_fin;
                out_dbz  <= dvs_zero;
            end
            if (load) begin
                qd       <= src_dvd[DVD_W-1] ? -src_dvd : src_dvd;
                dvs_q    <= src_dvs[DVS_W-1] ? -src_dvs : src_dvs;
                sign_q   <= src_dvd[DVD_W-1] ^ src_dvs[DVS_W-1];
                sign_r   <= src_dvd[DVD_W-1];
                dvs_zero <= src_dvs == '0;
                dvd_lo   <= src_dvd[DVS_W-1:0];
                r        <= '0;
                cnt      <= CW'(DVD_W - 1);
            end else if (state == CALC) begin
                r   <= r_nx;
                qd  <= qd_nx;
                cnt <= cnt - 1'b1;
            end
        end
    end

    // FIFO pointers; the extra MSB tells full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            mem_dvd[wr_ptr[AW-1:0]] <= in0_data;
            mem_dvs[wr_ptr[AW-1:0]] <= in1_data;
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard bench for div_seq
module tb_div_seq;
    logic        clk = 1'b0, rst_n = 1'b0, div_vld = 1'b0;
    logic [15:0] in0_data = '0;
    logic [7:0]  in1_data = '0;
    logic        in_rdy, div_busy, out_vld, out_dbz;
    logic [15:0] out_quot;
    logic [7:0]  out_rem;

    typedef struct packed {
        logic [15:0] quot;
        logic [7:0]  rem;
        logic        dbz;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0, checks = 0;

    div_seq dut (
        .clk(clk), .rst_n(rst_n), .div_vld(div_vld), .in0_data(in0_data), .in1_data(in1_data),
        .in_rdy(in_rdy), .div_busy(div_busy), .out_vld(out_vld), .out_quot(out_quot),
        .out_rem(out_rem), .out_dbz(out_dbz)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n) assert (!(div_vld && !in_rdy)) else $error("FAIL protocol: div_vld high while in_rdy=0");

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
        int sa, sb;
        exp_t e;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (b == 8'h00) begin
            e.quot = 16'hFFFF;
            e.rem  = a[7:0];
            e.dbz  = 1'b1;
        end else begin
            e.quot = 16'(sa / sb);
            e.rem  = 8'(sa % sb);
            e.dbz  = 1'b0;
        end
        return e;
    endfunction

    task automatic send(input logic [15:0] a, input logic [7:0] b);
        div_vld  = 1'b1;
        in0_data = a;
        in1_data = b;
        exp_q.push_back(model(a, b));
        @(posedge clk);
        @(negedge clk);
        div_vld = 1'b0;
    endtask

    task automatic wait_vld(input int limit, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_vld && cyc < limit);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_vld, out_dbz, out_quot, out_rem, div_busy} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs: got vld=%b dbz=%b q=%h r=%h busy=%b, want all 0",
                     out_vld, out_dbz, out_quot, out_rem, div_busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_rdy: got %b want 1", in_rdy);
        end
    endtask

    task automatic test_basic;
        int   cyc;
        exp_t e;
        send(16'h0064, 8'h07);
        wait_vld(40, cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc !== 17) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 17", cyc);
        end
        checks++;
        if ({out_quot, out_rem, out_dbz} !== {16'h000E, 8'h02, 1'b0} || {out_quot, out_rem, out_dbz} !== e) begin
            errors++;
            $display("FAIL basic_result: got %h/%h dbz=%b want 000e/02 dbz=0", out_quot, out_rem, out_dbz);
        end
        @(negedge clk);
        checks++;
        if ({out_vld, out_quot, out_rem} !== {1'b0, 16'h000E, 8'h02}) begin
            errors++;
            $display("FAIL basic_hold: got vld=%b %h/%h want vld=0 000e/02", out_vld, out_quot, out_rem);
        end
    endtask

    task automatic test_signs;
        logic [15:0] ta [8] = '{16'hFF9C, 16'h0064, 16'hFF9C, 16'h0000, 16'h8000, 16'h8000, 16'h7FFF, 16'h007F};
        logic [7:0]  tb [8] = '{8'h07,    8'hF9,    8'hF9,    8'h05,    8'hFF,    8'h80,    8'h7F,    8'h80};
        logic [23:0] tr [8] = '{24'hFFF2FE, 24'hFFF202, 24'h000EFE, 24'h000000,
                                24'h800000, 24'h010000, 24'h010201, 24'h00007F};
        int   cyc;
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            send(ta[k], tb[k]);
            wait_vld(40, cyc);
            e = exp_q.pop_front();
            checks++;
            if (!out_vld || {out_quot, out_rem, out_dbz} !== e || {out_quot, out_rem} !== tr[k]) begin
                errors++;
                $display("FAIL signs_%0d: %h/%h got vld=%b %h/%h dbz=%b want %h dbz=0",
                         k, ta[k], tb[k], out_vld, out_quot, out_rem, out_dbz, tr[k]);
            end
        end
    endtask

    task automatic test_dbz;
        int   cyc;
        exp_t e;
        send(16'h0005, 8'h00);
        wait_vld(40, cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc !== 1) begin
            errors++;
            $display("FAIL dbz_latency: got %0d want 1", cyc);
        end
        checks++;
        if ({out_quot, out_rem, out_dbz} !== {16'hFFFF, 8'h05, 1'b1} || {out_quot, out_rem, out_dbz} !== e) begin
            errors++;
            $display("FAIL dbz_result: got %h/%h dbz=%b want ffff/05 dbz=1", out_quot, out_rem, out_dbz);
        end
        send(16'h0006, 8'h03);
        wait_vld(40, cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc !== 17 || {out_quot, out_rem, out_dbz} !== {16'h0002, 8'h00, 1'b0} || {out_quot, out_rem, out_dbz} !== e) begin
            errors++;
            $display("FAIL dbz_after: got lat=%0d %h/%h dbz=%b want lat=17 0002/00 dbz=0",
                     cyc, out_quot, out_rem, out_dbz);
        end
    endtask

    task automatic test_burst;
        localparam int N = 20;
        int first_block = -1;
        fork
            begin
                int i = 0, g = 0;
                logic [15:0] a;
                logic [7:0]  b;
                while (i < N && g < 2000) begin
                    if (in_rdy) begin
                        a = 16'($urandom);
                        b = 8'($urandom_range(1, 255));
                        div_vld  = 1'b1;
                        in0_data = a;
                        in1_data = b;
                        exp_q.push_back(model(a, b));
                        i++;
                    end else begin
                        div_vld = 1'b0;
                        if (first_block < 0) first_block = i;
                    end
                    @(posedge clk);
                    @(negedge clk);
                    g++;
                end
                div_vld = 1'b0;
            end
            begin
                int   cyc;
                exp_t e;
                for (int j = 0; j < N; j++) begin
                    wait_vld(60, cyc);
                    checks++;
                    if (!out_vld) begin
                        errors++;
                        $display("FAIL burst_timeout: result %0d never arrived", j);
                        break;
                    end
                    if (j > 0) begin
                        checks++;
                        if (cyc !== 17) begin
                            errors++;
                            $display("FAIL burst_gap_%0d: got %0d want 17", j, cyc);
                        end
                    end
                    e = exp_q.pop_front();
                    checks++;
                    if ({out_quot, out_rem, out_dbz} !== e) begin
                        errors++;
                        $display("FAIL burst_data_%0d: got %h/%h dbz=%b want %h/%h dbz=%b",
                                 j, out_quot, out_rem, out_dbz, e.quot, e.rem, e.dbz);
                    end
                end
                checks++;
                if (div_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL burst_busy_last: got %b want 1", div_busy);
                end
                @(negedge clk);
                checks++;
                if ({div_busy, in_rdy} !== 2'b01 || exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL burst_drain: got busy=%b rdy=%b pending=%0d want busy=0 rdy=1 pending=0",
                             div_busy, in_rdy, exp_q.size());
                end
            end
        join
        checks++;
        if (first_block !== 17) begin
            errors++;
            $display("FAIL burst_fill: in_rdy dropped after %0d accepts, want 17", first_block);
        end
    endtask

    task automatic test_reset_mid;
        int   cyc, v;
        exp_t e;
        send(16'h03E8, 8'h03);
        send(16'hFE0C, 8'h07);
        send(16'h004D, 8'hFB);
        send(16'h3039, 8'h63);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_vld, out_dbz, out_quot, out_rem, div_busy} !== 27'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got vld=%b dbz=%b q=%h r=%h busy=%b, want all 0",
                     out_vld, out_dbz, out_quot, out_rem, div_busy);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_in_rdy: got %b want 1", in_rdy);
        end
        v = 0;
        repeat (60) begin
            @(negedge clk);
            if (out_vld) v++;
        end
        checks++;
        if (v !== 0) begin
            errors++;
            $display("FAIL midreset_no_vld: got %0d strobes want 0", v);
        end
        send(16'h0009, 8'h02);
        wait_vld(40, cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc !== 17 || {out_quot, out_rem, out_dbz} !== {16'h0004, 8'h01, 1'b0} || {out_quot, out_rem, out_dbz} !== e) begin
            errors++;
            $display("FAIL midreset_fresh: got lat=%0d %h/%h dbz=%b want lat=17 0004/01 dbz=0",
                     cyc, out_quot, out_rem, out_dbz);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_basic;
        test_signs;
        test_dbz;
        test_burst;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
